dm_write_tracer: RTL and testbench
==================================

// Module: dm_write_tracer
// PURPOSE
//  Parametrised data-memory write tracer attached to processor_arm's DM write port.
//  Captures every DM store (address, data, cycle stamp) that falls inside an address window
//  into a circular buffer. On a dump request, drains the captured stores oldest-first over a
//  valid/ready stream. Replaces end-of-run memory dumping with an ordered, timestamped store trace.
// PARAMETERS
//  N        64            DM address/data width
//  DEPTH    16            trace buffer entries (power of 2, >=2)
//  TSW      32            cycle-stamp width
//  ADDR_LO  0             lowest captured address (inclusive)
//  ADDR_HI  '1            highest captured address (inclusive)
//  WRAP     0             0: drop new stores when full; 1: overwrite oldest when full
// PORTS
//  CLOCK_50        in   1                system clock, all logic on rising edge
//  reset           in   1                asynchronous, active-high reset
//  DM_writeEnable  in   1                DM store strobe from processor
//  DM_addr         in   N                DM store address
//  DM_writeData    in   N                DM store data
//  dump            in   1                level; rising edge starts drain
//  out_valid       out  1                trace entry available
//  out_ready       in   1                consumer accepts entry
//  out_addr        out  N                entry address
//  out_data        out  N                entry data
//  out_stamp       out  TSW              cycle stamp of the store
//  count           out  $clog2(DEPTH)+1  entries currently held
//  overflow        out  1                sticky: a store was lost or overwritten
//  drain_done      out  1                drain finished, buffer empty
// BEHAVIOUR
//  - Reset (async, any state): state=CAPTURE, buffer empty, count=0, stamp=0, overflow=0,
//    out_valid=0, out_addr/out_data/out_stamp=0, drain_done=0.
//  - stamp: free-running TSW-bit counter, +1 every cycle, wraps modulo 2^TSW.
//  - CAPTURE: on a cycle with DM_writeEnable=1 and ADDR_LO<=DM_addr<=ADDR_HI, store
//    {DM_addr, DM_writeData, stamp}. count reflects the store after that edge (1-cycle latency).
//    Full and WRAP=0: store dropped, overflow<=1. Full and WRAP=1: oldest overwritten,
//    count stays DEPTH, overflow<=1.
//  - Rising edge of dump (registered compare with previous dump): a store in the same cycle is
//    still captured, then state->DRAIN. If the buffer is empty (incl. that store), state->DONE.
//  - DRAIN: out_valid asserts the cycle after entry. Entries go out oldest-first. out_* stable
//    while out_valid=1 and out_ready=0. A transfer occurs when out_valid && out_ready. The next
//    entry is presented on the following cycle (back-to-back, 1 entry/cycle when out_ready=1).
//    Stores arriving during DRAIN/DONE are dropped and set overflow.
//  - After the last transfer: out_valid<=0, state->DONE, drain_done<=1.
//  - DONE: when dump=0, drain_done<=0, overflow<=0, state->CAPTURE. The buffer is already empty.
//  - Dump held high throughout does not retrigger. Only a new 0->1 edge does.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. count saturates at DEPTH.
// STRUCTURE
//  - trace_pkg: trace_entry_t struct {addr[N], data[N], stamp[TSW]}, tracer_state_e
//    {CAPTURE, DRAIN, DONE}.
//  - Sub-module trace_fifo: circular buffer (wr/rd pointers, count, full/empty, overwrite-oldest
//    push) parametrised by DEPTH and entry type.
//  - The top holds address window compare, stamp counter, dump edge detect, FSM and output register.
// TESTING
//  1 Reset mid-DRAIN with 5 entries held -> next cycle out_valid=0, count=0, overflow=0,
//    state CAPTURE.
//  2 Stores to 0x0,0x8,0x10 (data 1,2,3), dump 0->1, out_ready=1 -> three beats in order,
//    stamps increasing, then drain_done=1.
//  3 WRAP=0, DEPTH=4, 6 stores -> count=4, overflow=1. Drain yields the first 4 stores only.
//  4 WRAP=1, DEPTH=4, 6 stores -> drain yields stores 3..6. overflow=1.
//  5 ADDR_LO=0x100, ADDR_HI=0x1FF; stores to 0x0F8, 0x100, 0x1FF, 0x200 -> only 0x100 and
//    0x1FF captured.
//  6 out_ready toggled 1,0,0,1 during drain -> out_* unchanged across stall, no entry lost
//    or duplicated. Dump in an empty buffer -> drain_done next cycle, out_valid never 1.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the DM write tracer.
//   trace_entry_t  : one captured store {addr, data, stamp} at the default widths.
//                    Instances size their own copy with the same field order.
//   tracer_state_e : top-level tracer FSM states.
package trace_pkg;

    localparam int unsigned TRACE_N_DEFAULT   = 64;
    localparam int unsigned TRACE_TSW_DEFAULT = 32;

    typedef struct packed {
        logic [TRACE_N_DEFAULT-1:0]   addr;
        logic [TRACE_N_DEFAULT-1:0]   data;
        logic [TRACE_TSW_DEFAULT-1:0] stamp;
    } trace_entry_t;

    typedef enum logic [1:0] {
        CAPTURE,
        DRAIN,
        DONE
    } tracer_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write wr_data (dropped when full unless WRAP=1, which overwrites the oldest)
//   pop        : discard the entry at rd_data (ignored when empty)
//   wr_data    : entry to store
//   rd_data    : oldest entry held
//   count      : entries held, saturates at DEPTH
//   full/empty : occupancy flags
module trace_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter bit          WRAP    = 1'b0,
    parameter type         entry_t = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 wr_data,
    output entry_t                 rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop_ok;
    logic            push_ok;
    logic            overwrite;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok || WRAP);
    // Overwriting the oldest entry advances the read pointer with the write pointer.
    assign overwrite = push && full && !pop_ok && WRAP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok && !overwrite) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/dm_write_tracer.sv
// Data-memory write tracer for processor_arm's DM write port.
// Captures in-window stores with a cycle stamp into a circular buffer and, on a
// rising edge of dump, drains them oldest-first over a valid/ready stream.
//   CLOCK_50, reset             : clock, asynchronous active-high reset
//   DM_writeEnable/addr/writeData : store strobe, address and data
//   dump                        : level input; a 0->1 edge starts a drain
//   out_valid/out_ready         : stream handshake
//   out_addr/out_data/out_stamp : presented trace entry
//   count                       : entries held in the buffer
//   overflow                    : sticky, a store was lost or overwritten
//   drain_done                  : drain finished, buffer empty
module dm_write_tracer
    import trace_pkg::*;
#(
    parameter int unsigned    N       = 64,
    parameter int unsigned    DEPTH   = 16,
    parameter int unsigned    TSW     = 32,
    parameter logic [N-1:0]   ADDR_LO = '0,
    parameter logic [N-1:0]   ADDR_HI = '1,
    parameter bit             WRAP    = 1'b0
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   DM_writeEnable,
    input  logic [N-1:0]           DM_addr,
    input  logic [N-1:0]           DM_writeData,
    input  logic                   dump,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_addr,
    output logic [N-1:0]           out_data,
    output logic [TSW-1:0]         out_stamp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   drain_done
);

    // Same field order as trace_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [N-1:0]   addr;
        logic [N-1:0]   data;
        logic [TSW-1:0] stamp;
    } entry_t;

    tracer_state_e  state;
    tracer_state_e  state_nxt;
    logic [TSW-1:0] stamp_cnt;
    logic           dump_q;
    logic           dump_rise;
    logic           lo_ok;
    logic           hi_ok;
    logic           hit;
    entry_t         wr_entry;
    entry_t         rd_entry;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic           load_out;
    logic           finish_drain;
    logic           set_done;
    logic           set_overflow;
    logic           clear_done;

    // Open window bounds are resolved at elaboration so no constant compare is built.
    if (ADDR_LO == '0) begin : g_lo_open
        assign lo_ok = 1'b1;
    end else begin : g_lo
        assign lo_ok = (DM_addr >= ADDR_LO);
    end

    if (ADDR_HI == '1) begin : g_hi_open
        assign hi_ok = 1'b1;
    end else begin : g_hi
        assign hi_ok = (DM_addr <= ADDR_HI);
    end

    assign hit       = DM_writeEnable && lo_ok && hi_ok;
    assign dump_rise = dump && !dump_q;
    assign wr_entry  = '{addr: DM_addr, data: DM_writeData, stamp: stamp_cnt};

    trace_fifo #(
        .DEPTH   (DEPTH),
        .WRAP    (WRAP),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst     (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        load_out     = 1'b0;
        finish_drain = 1'b0;
        set_done     = 1'b0;
        set_overflow = 1'b0;
        clear_done   = 1'b0;
        case (state)
            CAPTURE: begin
                fifo_push    = hit;
                set_overflow = hit && fifo_full;
                // A store in the dump cycle is still captured, so it counts toward non-empty.
                if (dump_rise) begin
                    if (fifo_empty && !hit) begin
                        state_nxt = DONE;
                        set_done  = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                set_overflow = hit;
                // Output register is free when empty or being accepted this cycle.
                if (!out_valid || out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        load_out = 1'b1;
                    end else begin
                        finish_drain = 1'b1;
                        set_done     = 1'b1;
                        state_nxt    = DONE;
                    end
                end
            end
            DONE: begin
                set_overflow = hit;
                if (!dump) begin
                    clear_done = 1'b1;
                    state_nxt  = CAPTURE;
                end
            end
            default: state_nxt = CAPTURE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            stamp_cnt  <= '0;
            dump_q     <= 1'b0;
            overflow   <= 1'b0;
            drain_done <= 1'b0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            out_stamp  <= '0;
        end else begin
            stamp_cnt <= stamp_cnt + 1'b1;
            dump_q    <= dump;
            // A store lost on the DONE exit cycle still leaves overflow set.
            if (set_overflow) begin
                overflow <= 1'b1;
            end else if (clear_done) begin
                overflow <= 1'b0;
            end
            if (set_done) begin
                drain_done <= 1'b1;
            end else if (clear_done) begin
                drain_done <= 1'b0;
            end
            if (load_out) begin
                out_valid <= 1'b1;
                out_addr  <= rd_entry.addr;
                out_data  <= rd_entry.data;
                out_stamp <= rd_entry.stamp;
            end else if (finish_drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dm_write_tracer.sv
// Self-checking bench for dm_write_tracer.
// Three instances share stimulus; each test resets them all and checks the one it targets:
//   t0: DEPTH=16, WRAP=0, full window
//   t1: DEPTH=4,  WRAP=0, window 0x100..0x1FF
//   t2: DEPTH=4,  WRAP=1, full window
module tb_dm_write_tracer;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        dump;
    logic        ready;

    logic        ov  [3];
    logic [63:0] oa  [3];
    logic [63:0] od  [3];
    logic [31:0] os  [3];
    logic        ofl [3];
    logic        dd  [3];
    logic [4:0]  cnt0;
    logic [2:0]  cnt1;
    logic [2:0]  cnt2;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [31:0] s;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tb_stamp;
    int          tests_run    = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    // Reference cycle counter used to predict each store's stamp.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_stamp <= '0;
        else     tb_stamp <= tb_stamp + 1;
    end

    dm_write_tracer #(.N(64), .DEPTH(16), .TSW(32), .WRAP(1'b0)) u_t0 (
        .CLOCK_50(clk), .reset(rst), .DM_writeEnable(we), .DM_addr(addr), .DM_writeData(wdata),
        .dump(dump), .out_valid(ov[0]), .out_ready(ready), .out_addr(oa[0]), .out_data(od[0]),
        .out_stamp(os[0]), .count(cnt0), .overflow(ofl[0]), .drain_done(dd[0]));

    dm_write_tracer #(.N(64), .DEPTH(4), .TSW(32), .ADDR_LO(64'h100), .ADDR_HI(64'h1FF),
                      .WRAP(1'b0)) u_t1 (
        .CLOCK_50(clk), .reset(rst), .DM_writeEnable(we), .DM_addr(addr), .DM_writeData(wdata),
        .dump(dump), .out_valid(ov[1]), .out_ready(ready), .out_addr(oa[1]), .out_data(od[1]),
        .out_stamp(os[1]), .count(cnt1), .overflow(ofl[1]), .drain_done(dd[1]));

    dm_write_tracer #(.N(64), .DEPTH(4), .TSW(32), .WRAP(1'b1)) u_t2 (
        .CLOCK_50(clk), .reset(rst), .DM_writeEnable(we), .DM_addr(addr), .DM_writeData(wdata),
        .dump(dump), .out_valid(ov[2]), .out_ready(ready), .out_addr(oa[2]), .out_data(od[2]),
        .out_stamp(os[2]), .count(cnt2), .overflow(ofl[2]), .drain_done(dd[2]));

    function automatic logic [4:0] cnt_of(input int inst);
        case (inst)
            0:       return cnt0;
            1:       return {2'b00, cnt1};
            default: return {2'b00, cnt2};
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; we = 1'b0; dump = 1'b0; ready = 1'b0; addr = '0; wdata = '0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one store for the next rising edge; we stays high until idle()/start_dump().
    task automatic store(input logic [63:0] a, input logic [63:0] d, input bit expect_kept);
        exp_t e;
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        e.a = a; e.d = d; e.s = tb_stamp;
        if (expect_kept) exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic start_dump();
        @(negedge clk);
        we = 1'b0; dump = 1'b1;
    endtask

    task automatic end_dump(input int inst);
        @(negedge clk);
        dump = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dd[inst] !== 1'b0) begin
            tests_failed++;
            $display("FAIL end_dump_done[%0d]: got %b expected 0", inst, dd[inst]);
        end
        tests_run++;
        if (ofl[inst] !== 1'b0) begin
            tests_failed++;
            $display("FAIL end_dump_overflow[%0d]: got %b expected 0", inst, ofl[inst]);
        end
    endtask

    // Pops the scoreboard on every accepted beat; pat[c%4] drives out_ready.
    task automatic drain(input int inst, input logic [3:0] pat, input string tag);
        exp_t        e;
        bit          stalled = 1'b0;
        bit          done    = 1'b0;
        logic [63:0] sa, sd;
        logic [31:0] ss;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            ready = pat[c % 4];
            if (dd[inst] === 1'b1) begin
                done = 1'b1;
            end else begin
                if (stalled) begin
                    tests_run++;
                    if (oa[inst] !== sa || od[inst] !== sd || os[inst] !== ss || ov[inst] !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL %s_stall: got v=%b a=%h d=%h s=%h expected v=1 a=%h d=%h s=%h",
                                 tag, ov[inst], oa[inst], od[inst], os[inst], sa, sd, ss);
                    end
                end
                stalled = ov[inst] && !ready;
                sa = oa[inst]; sd = od[inst]; ss = os[inst];
                if (ov[inst] === 1'b1 && ready) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL %s_extra_beat: got a=%h d=%h expected no beat", tag, oa[inst], od[inst]);
                    end else begin
                        e = exp_q.pop_front();
                        if (oa[inst] !== e.a || od[inst] !== e.d || os[inst] !== e.s) begin
                            tests_failed++;
                            $display("FAIL %s_beat: got a=%h d=%h s=%h expected a=%h d=%h s=%h",
                                     tag, oa[inst], od[inst], os[inst], e.a, e.d, e.s);
                        end
                    end
                end
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s_timeout: got drain_done=0 expected 1 within 80 cycles", tag);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing: got %0d beats outstanding expected 0", tag, exp_q.size());
        end
        tests_run++;
        if (ov[inst] !== 1'b0 || cnt_of(inst) !== 5'd0) begin
            tests_failed++;
            $display("FAIL %s_after: got valid=%b count=%0d expected valid=0 count=0", tag, ov[inst], cnt_of(inst));
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (ov[i] !== 1'b0 || oa[i] !== '0 || od[i] !== '0 || os[i] !== '0 ||
                ofl[i] !== 1'b0 || dd[i] !== 1'b0 || cnt_of(i) !== 5'd0) begin
                tests_failed++;
                $display("FAIL reset_state[%0d]: got v=%b a=%h d=%h s=%h ofl=%b dd=%b cnt=%0d expected all 0",
                         i, ov[i], oa[i], od[i], os[i], ofl[i], dd[i], cnt_of(i));
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        for (int i = 0; i < 5; i++) store(64'(i * 8), 64'(100 + i), 1'b0);
        @(negedge clk);
        we = 1'b0; dump = 1'b1; ready = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ov[0] !== 1'b1 || cnt0 !== 5'd4) begin
            tests_failed++;
            $display("FAIL mid_drain_pre: got valid=%b count=%0d expected valid=1 count=4", ov[0], cnt0);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (ov[0] !== 1'b0 || cnt0 !== 5'd0 || ofl[0] !== 1'b0 || dd[0] !== 1'b0 || oa[0] !== '0) begin
            tests_failed++;
            $display("FAIL mid_drain_reset: got v=%b cnt=%0d ofl=%b dd=%b a=%h expected all 0",
                     ov[0], cnt0, ofl[0], dd[0], oa[0]);
        end
        @(negedge clk);
        rst = 1'b0; dump = 1'b0;
        exp_q.delete();
        // Back in CAPTURE: a fresh store is taken and drains.
        store(64'h40, 64'h55, 1'b1);
        idle();
        tests_run++;
        if (cnt0 !== 5'd1) begin
            tests_failed++;
            $display("FAIL post_reset_capture: got count=%0d expected 1", cnt0);
        end
        start_dump();
        drain(0, 4'b1111, "post_reset");
        end_dump(0);
    endtask

    task automatic test_basic_drain();
        apply_reset();
        store(64'h0,  64'd1, 1'b1);
        store(64'h8,  64'd2, 1'b1);
        store(64'h10, 64'd3, 1'b1);
        idle();
        tests_run++;
        if (cnt0 !== 5'd3 || ofl[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_count: got count=%0d ofl=%b expected count=3 ofl=0", cnt0, ofl[0]);
        end
        start_dump();
        drain(0, 4'b1111, "basic");
        end_dump(0);
    endtask

    task automatic test_full_drop();
        apply_reset();
        for (int i = 0; i < 6; i++) store(64'h100 + 64'(i * 8), 64'(i + 1), i < 4);
        idle();
        tests_run++;
        if (cnt1 !== 3'd4 || ofl[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_full: got count=%0d ofl=%b expected count=4 ofl=1", cnt1, ofl[1]);
        end
        start_dump();
        drain(1, 4'b1111, "drop");
        end_dump(1);
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 6; i++) store(64'h200 + 64'(i * 8), 64'(i + 1), i >= 2);
        idle();
        tests_run++;
        if (cnt2 !== 3'd4 || ofl[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_full: got count=%0d ofl=%b expected count=4 ofl=1", cnt2, ofl[2]);
        end
        start_dump();
        drain(2, 4'b1111, "wrap");
        end_dump(2);
    endtask

    task automatic test_window();
        apply_reset();
        store(64'h0F8, 64'hA, 1'b0);
        store(64'h100, 64'hB, 1'b1);
        store(64'h1FF, 64'hC, 1'b1);
        store(64'h200, 64'hD, 1'b0);
        idle();
        tests_run++;
        if (cnt1 !== 3'd2 || ofl[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL window_count: got count=%0d ofl=%b expected count=2 ofl=0", cnt1, ofl[1]);
        end
        start_dump();
        drain(1, 4'b1111, "window");
        end_dump(1);
    endtask

    task automatic test_back_to_back_stall();
        apply_reset();
        for (int i = 0; i < 4; i++) store(64'h1000 + 64'(i * 16), 64'hBEEF0 + 64'(i), 1'b1);
        idle();
        start_dump();
        drain(0, 4'b1001, "stall");
        end_dump(0);
    endtask

    task automatic test_empty_dump();
        bit seen_valid = 1'b0;
        apply_reset();
        ready = 1'b1;
        @(negedge clk);
        dump = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dd[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_dump_done: got %b expected 1", dd[0]);
        end
        for (int c = 0; c < 4; c++) begin
            if (ov[0] !== 1'b0) seen_valid = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (seen_valid || ov[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_dump_valid: got out_valid=1 expected never 1");
        end
        end_dump(0);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; dump = 1'b0; ready = 1'b0; addr = '0; wdata = '0;
        #1;
        test_reset();
        test_reset_mid_drain();
        test_basic_drain();
        test_full_drop();
        test_full_wrap();
        test_window();
        test_back_to_back_stall();
        test_empty_dump();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
